riscv_ifetch: RTL and testbench

//  Instruction fetch front-end. Producer side of the core's pc/instr interface.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/riscv_sync_fifo.sv | 72 +++++++
 rtl/riscv_ifetch.sv | 126 ++++++++++++
 tb/tb_riscv_ifetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the instruction fetch front-end
package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] HALT_INSTR = 32'h00100073;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_FAULT
  } ifetch_state_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// rtl/riscv_sync_fifo.sv - synchronous FIFO with flush, count and full/empty flags
module riscv_sync_fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    // Flush dominates any push or pop presented in the same cycle.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_ifetch.sv
// rtl/riscv_ifetch.sv - in-order instruction fetch with credit-based buffering, redirect and halt
module riscv_ifetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted,
  output logic            fault
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  ifetch_state_t   state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic            accept;
  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_in;

  // Credit check counts in-flight reads against free FIFO slots so a response always has room.
  assign req_valid = rst_n && (state_q == ST_RUN) && !redirect_valid
                   && (int'(out_q) < MAX_OUT)
                   && (int'(fifo_count) + int'(out_q) < DEPTH);
  assign req_addr  = fetch_pc_q;
  assign accept    = req_valid && req_ready;

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign halted      = (state_q == ST_HALTED);
  assign fault       = (state_q == ST_FAULT);
  assign fifo_in     = '{instr: resp_data, pc: resp_pc_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      // Every read still in flight after this edge belongs to the old stream.
      fifo_flush = 1'b1;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      out_d      = out_q - OW'(resp_valid);
      drop_d     = out_q - OW'(resp_valid);
      state_d    = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
    end else begin
      fifo_pop = instr_valid && instr_ready;
      if (accept) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      out_d = out_q + OW'(accept) - OW'(resp_valid);
      if (resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else if (state_q == ST_RUN && !fifo_full) begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + XLEN'(4);
          if (resp_data == HALT_INSTR) begin
            state_d = ST_HALTED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  riscv_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_riscv_ifetch.sv
// tb/tb_riscv_ifetch.sv - self-checking bench for riscv_ifetch against a stream-level reference model
module tb_riscv_ifetch;
  import riscv_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int M_RUN   = 0;
  localparam int M_HALT  = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted, fault;

  riscv_ifetch #(.XLEN(64), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } mem_ent_t;

  typedef struct {
    logic [63:0] rpc;
    bit          exp_fault;
  } redir_vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  mem_ent_t    mq[$];
  logic [63:0] pop_log[$];
  int          cyc = 0, last_due = 0, epoch = 0, mstate = M_RUN, mbuf = 0;
  int          n_pops = 0, n_acc = 0;
  logic [63:0] exp_fetch_pc = 64'h0, exp_deliver_pc = 64'h0;
  int          rdy_pct = 100, core_pct = 100, lat_min = 1, lat_max = 1;
  bit          redir_req = 1'b0;
  logic [63:0] redir_target = 64'h0;
  bit          halt_en = 1'b0;
  logic [63:0] halt_addr = 64'h8;
  redir_vec_t  vecs[5];

  function automatic logic [31:0] memword(input logic [63:0] a);
    if (halt_en && a == halt_addr) return HALT_INSTR;
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: entered and left at a falling edge with outputs settled.
  task automatic cycle();
    mem_ent_t e;
    bit       rsp, acc, pop, push;
    int       d;
    push = 1'b0;
    req_ready      = ($urandom_range(99) < rdy_pct);
    instr_ready    = ($urandom_range(99) < core_pct);
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    redir_req      = 1'b0;
    rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
    resp_valid     = rsp;
    resp_data      = rsp ? memword(mq[0].addr) : 32'h0;
    #1;
    chk("halted", 64'(halted), 64'(mstate == M_HALT));
    chk("fault", 64'(fault), 64'(mstate == M_FAULT));
    chk("instr_valid", 64'(instr_valid), 64'(mbuf > 0));
    chk("req_valid", 64'(req_valid), 64'(mstate == M_RUN && !redirect_valid
        && mq.size() < MAX_OUT && mbuf + mq.size() < DEPTH));
    if (req_valid) chk("req_addr", req_addr, exp_fetch_pc);
    acc = req_valid && req_ready;
    pop = instr_valid && instr_ready && !redirect_valid;
    if (pop) begin
      chk("instr_pc", instr_pc, exp_deliver_pc);
      chk("instr", 64'(instr), 64'(memword(exp_deliver_pc)));
      pop_log.push_back(instr_pc);
      n_pops++;
      exp_deliver_pc += 64'd4;
    end
    if (rsp) begin
      e    = mq.pop_front();
      push = !redirect_valid && e.epoch == epoch && mstate == M_RUN;
    end
    if (acc) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: req_addr, epoch: epoch, due: d});
      exp_fetch_pc += 64'd4;
      n_acc++;
    end
    if (redirect_valid) begin
      epoch++;
      mbuf           = 0;
      exp_fetch_pc   = redirect_pc;
      exp_deliver_pc = redirect_pc;
      mstate         = (redirect_pc[1:0] != 2'b00) ? M_FAULT : M_RUN;
    end else begin
      mbuf = mbuf + int'(push) - int'(pop);
      if (push && memword(e.addr) == HALT_INSTR) mstate = M_HALT;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redir_req    = 1'b1;
    redir_target = pc;
    pop_log.delete();
    cycle();
  endtask

  initial begin
    int k, p0, a0;
    vecs[0] = '{rpc: 64'h102, exp_fault: 1'b1};
    vecs[1] = '{rpc: 64'h40, exp_fault: 1'b0};
    vecs[2] = '{rpc: 64'h203, exp_fault: 1'b1};
    vecs[3] = '{rpc: 64'h1000, exp_fault: 1'b0};
    vecs[4] = '{rpc: 64'hFFFF_FFFF_FFFF_FFF8, exp_fault: 1'b0};

    rst_n = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_addr", req_addr, 64'h0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    rst_n = 1'b1;

    // 1: streaming from reset
    run(12);
    chk("t1_pops", 64'(pop_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("t1_pc_order", pop_log[i], 64'(i * 4));

    // 2: core stalls, buffer fills to DEPTH, then drains without loss
    core_pct = 0;
    run(12);
    chk("t2_req_low", 64'(req_valid), 64'd0);
    chk("t2_fifo_count", 64'(dut.fifo_count), 64'd4);
    chk("t2_no_inflight", 64'(mq.size()), 64'd0);
    rdy_pct = 0; core_pct = 100; p0 = n_pops;
    run(8);
    chk("t2_drained", 64'(n_pops - p0), 64'd4);
    rdy_pct = 100;

    // 3: redirect with two reads in flight
    lat_min = 3; lat_max = 3;
    k = 0;
    while (mq.size() != 2 && k < 30) begin cycle(); k++; end
    chk("t3_two_outstanding", 64'(mq.size()), 64'd2);
    redirect_to(64'h100);
    chk("t3_flushed", 64'(instr_valid), 64'd0);
    run(15);
    chk("t3_got_output", 64'(pop_log.size() > 0), 64'd1);
    if (pop_log.size() > 0) chk("t3_first_pc", pop_log[0], 64'h100);

    // 4: redirect coincident with a response and a core pop
    lat_min = 2; lat_max = 2; core_pct = 0;
    k = 0;
    while (!(mq.size() == 2 && mq[0].due <= cyc && instr_valid) && k < 40) begin cycle(); k++; end
    chk("t4_setup", 64'(mq.size() == 2 && mq[0].due <= cyc && instr_valid), 64'd1);
    core_pct = 100;
    redirect_to(64'h200);
    chk("t4_drop_cnt", 64'(dut.drop_q), 64'd1);
    chk("t4_flushed", 64'(instr_valid), 64'd0);
    run(15);
    chk("t4_got_output", 64'(pop_log.size() > 0), 64'd1);
    if (pop_log.size() > 0) chk("t4_first_pc", pop_log[0], 64'h200);

    // 5: HALT at pc 0x8, then resume
    lat_min = 1; lat_max = 1; halt_en = 1'b1; halt_addr = 64'h8;
    redirect_to(64'h0);
    k = 0;
    while (!halted && k < 40) begin cycle(); k++; end
    chk("t5_halted", 64'(halted), 64'd1);
    run(3);
    chk("t5_last_pc", (pop_log.size() > 0) ? pop_log[pop_log.size()-1] : 64'hDEAD, 64'h8);
    a0 = n_acc;
    run(10);
    chk("t5_no_req", 64'(n_acc - a0), 64'd0);
    chk("t5_still_halted", 64'(halted), 64'd1);
    halt_en = 1'b0;
    redirect_to(64'h0);
    run(10);
    chk("t5_resumed", 64'(halted), 64'd0);
    chk("t5_resume_pc", (pop_log.size() > 0) ? pop_log[0] : 64'hDEAD, 64'h0);

    // 6: redirect vector table with random memory latency
    lat_min = 1; lat_max = 3;
    for (int v = 0; v < 5; v++) begin
      redirect_to(vecs[v].rpc);
      chk("t6_fault", 64'(fault), 64'(vecs[v].exp_fault));
      if (vecs[v].exp_fault) chk("t6_req_blocked", 64'(req_valid), 64'd0);
      run(16);
      if (vecs[v].exp_fault) chk("t6_no_output", 64'(pop_log.size()), 64'd0);
      else chk("t6_first_pc", (pop_log.size() > 0) ? pop_log[0] : 64'hDEAD, vecs[v].rpc);
    end

    // random traffic with occasional redirects and a HALT word in range
    halt_en = 1'b1; halt_addr = 64'h1040;
    redirect_to(64'h1000);
    rdy_pct = 60; core_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(29) == 0) begin
        redir_req    = 1'b1;
        redir_target = 64'h1000 + 64'($urandom_range(63)) * 64'd4;
        if ($urandom_range(7) == 0) redir_target += 64'($urandom_range(3, 1));
      end
      cycle();
    end
    chk("t6_random_progress", 64'(n_pops > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
